// File: rtl/gate_bist_ctrl_pkg.sv
// Shared definitions for the gate BIST controller: FSM state encoding and
// truth tables of the common two-input gates.
package gate_bist_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Bit k is the gate output for input vector k (in1 = MSB of k).
    localparam logic [3:0] TT_NAND2 = 4'b0111;
    localparam logic [3:0] TT_NOR2  = 4'b0001;
    localparam logic [3:0] TT_AND2  = 4'b1000;
    localparam logic [3:0] TT_OR2   = 4'b1110;
    localparam logic [3:0] TT_XOR2  = 4'b0110;

endpackage

// File: rtl/bist_settle_cnt.sv
// Settle-time counter: counts enabled cycles from zero and flags the last
// settle cycle on tc; clr restarts the count for the next vector.
module bist_settle_cnt #(
    parameter int unsigned SETTLE_CYC = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int unsigned W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [W-1:0] LAST = W'(SETTLE_CYC - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = (cnt == LAST);

endmodule

// File: rtl/gate_bist_ctrl.sv
// Hardware self-test front end for a small combinational gate: walks every
// input vector, samples the gate after a settle time and logs mismatches.
//
// state  | meaning
// IDLE   | waiting for start after reset
// SETTLE | vector applied, waiting SETTLE_CYC cycles for the gate to settle
// SAMPLE | compare gate output to TRUTH, then advance or finish
// DONE   | results held; start launches a fresh run
module gate_bist_ctrl
    import gate_bist_ctrl_pkg::*;
#(
    parameter int unsigned N_IN       = 2,
    parameter int unsigned SETTLE_CYC = 2,
    parameter logic [2**N_IN-1:0] TRUTH = TT_NAND2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic [N_IN-1:0]     dut_in,
    input  logic                dut_out,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [N_IN:0]       fail_cnt,
    output logic [N_IN-1:0]     first_fail_vec,
    output logic [2**N_IN-1:0]  mismatch_map
);

    localparam logic [N_IN-1:0] LAST_VEC = {N_IN{1'b1}};

    state_t state, state_next;
    logic   launch;
    logic   cnt_clr;
    logic   cnt_en;
    logic   settle_tc;
    logic   mismatch;

    bist_settle_cnt #(.SETTLE_CYC(SETTLE_CYC)) u_settle_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .en  (cnt_en),
        .tc  (settle_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        launch     = 1'b0;
        cnt_clr    = 1'b0;
        cnt_en     = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    launch     = 1'b1;
                    cnt_clr    = 1'b1;
                    state_next = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                cnt_en = 1'b1;
                if (settle_tc) begin
                    state_next = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                if (dut_in == LAST_VEC) begin
                    state_next = ST_DONE;
                end else begin
                    cnt_clr    = 1'b1;
                    state_next = ST_SETTLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Case inequality so a floating (X/Z) gate output is flagged as a failure.
    assign mismatch = (dut_out !== TRUTH[dut_in]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dut_in         <= '0;
            fail_cnt       <= '0;
            first_fail_vec <= '0;
            mismatch_map   <= '0;
        end else if (launch) begin
            dut_in         <= '0;
            fail_cnt       <= '0;
            first_fail_vec <= '0;
            mismatch_map   <= '0;
        end else if (state == ST_SAMPLE) begin
            if (mismatch) begin
                mismatch_map[dut_in] <= 1'b1;
                fail_cnt             <= fail_cnt + 1'b1;
                if (fail_cnt == '0) begin
                    first_fail_vec <= dut_in;
                end
            end
            if (dut_in != LAST_VEC) begin
                dut_in <= dut_in + 1'b1;
            end
        end
    end

    assign busy = (state == ST_SETTLE) || (state == ST_SAMPLE);
    assign done = (state == ST_DONE);
    assign pass = done && (fail_cnt == '0);

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Directed plus randomized bench for gate_bist_ctrl with default parameters;
// the gate under test is modelled by a 4-bit truth table the bench picks.
module tb_gate_bist_ctrl;
    import gate_bist_ctrl_pkg::*;

    localparam int SETTLE = 2;
    localparam int NVEC   = 4;
    localparam int RUN    = NVEC * (SETTLE + 1);

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] dut_in;
    logic       dut_out;
    logic       busy, done, pass;
    logic [2:0] fail_cnt;
    logic [1:0] first_fail_vec;
    logic [3:0] mismatch_map;

    logic [3:0] gate_tt;
    int         n_pass  = 0;
    int         n_total = 0;

    gate_bist_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .dut_in         (dut_in),
        .dut_out        (dut_out),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .fail_cnt       (fail_cnt),
        .first_fail_vec (first_fail_vec),
        .mismatch_map   (mismatch_map)
    );

    assign dut_out = gate_tt[dut_in];

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One complete run from IDLE or DONE against a gate with truth table gtt.
    task automatic run_test(input logic [3:0] gtt, input bit repulse);
        logic [3:0] e_map;
        int         e_cnt;
        int         e_first;
        bit         found;
        e_map = '0; e_cnt = 0; e_first = 0; found = 0;
        for (int k = 0; k < NVEC; k++) begin
            if (gtt[k] != TT_NAND2[k]) begin
                e_map[k] = 1'b1;
                e_cnt++;
                if (!found) begin
                    e_first = k;
                    found = 1;
                end
            end
        end
        gate_tt = gtt;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= RUN; c++) begin
            if (c == 1) begin
                chk("cleared_fail_cnt", fail_cnt, 0);
                chk("cleared_map", mismatch_map, 0);
            end
            chk("busy_in_run", busy, 1);
            chk("done_in_run", done, 0);
            chk("vector_seq", dut_in, (c - 1) / (SETTLE + 1));
            start = repulse && (c == 4 || c == RUN - 1);
            @(negedge clk);
        end
        start = 1'b0;
        chk("done_at_13", done, 1);
        chk("busy_at_done", busy, 0);
        chk("fail_cnt", fail_cnt, e_cnt);
        chk("mismatch_map", mismatch_map, e_map);
        chk("first_fail_vec", first_fail_vec, e_first);
        chk("pass", pass, (e_cnt == 0));
        @(negedge clk);
        chk("done_held", done, 1);
        chk("fail_cnt_held", fail_cnt, e_cnt);
        chk("vector_held", dut_in, 3);
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        gate_tt = TT_NAND2;
        repeat (2) @(negedge clk);
        chk("rst_dut_in", dut_in, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_fail_cnt", fail_cnt, 0);
        chk("rst_first_fail", first_fail_vec, 0);
        chk("rst_map", mismatch_map, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_no_start", busy, 0);

        run_test(TT_NAND2, 0);
        run_test(4'b1111, 0);
        run_test(TT_NAND2, 1);
        run_test(TT_AND2, 0);
        run_test(4'b0000, 0);
        run_test(TT_XOR2, 1);
        repeat (8) run_test(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));

        // Reset while vector 2 is applied, after two failures have been logged.
        gate_tt = 4'b0000;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        chk("pre_rst_vector", dut_in, 2);
        chk("pre_rst_fail_cnt", fail_cnt, 2);
        rst = 1'b1;
        #1;
        chk("midrst_dut_in", dut_in, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_fail_cnt", fail_cnt, 0);
        chk("midrst_map", mismatch_map, 0);
        @(negedge clk);
        rst = 1'b0;
        run_test(TT_NAND2, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
